// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types and helpers for the pulse_gen / pulse_stretch family
// Contents:
//   pstate_e : stretcher FSM state (IDLE, STRETCH, GUARD)
//   max2     : elaboration-time maximum of two integers, used for counter sizing
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    GUARD   = 2'd2
  } pstate_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter that saturates at zero
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count to 0
//   load     : load load_val this cycle (wins over dec)
//   load_val : value to load
//   dec      : decrement by one when the count is non-zero
//   zero     : count is zero (decoded from the register)
module pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (load) begin
      tmr_d = load_val;
    end else if (dec && (tmr_q != '0)) begin
      tmr_d = tmr_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign zero = (tmr_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches one-cycle strobes into fixed-width, spaced level windows
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   pulse_sig  : input strobe, sampled every edge
//   clr_missed : clears the sticky missed flag
//   level_sig  : high while stretching (decoded from registered state)
//   busy       : high whenever the FSM is not idle
//   missed     : sticky, set when a pulse is rejected
//   pulse_cnt  : count of accepted pulses, wraps modulo 2^CNT_W
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int GAP    = 2,
  parameter int RETRIG = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_sig,
  input  logic             clr_missed,
  output logic             level_sig,
  output logic             busy,
  output logic             missed,
  output logic [CNT_W-1:0] pulse_cnt
);

  if ((WIDTH < 1) || (GAP < 0) || (CNT_W < 1)) begin : g_bad_params
    $error("pulse_stretch: illegal parameter set");
  end

  localparam int TMR_W = $clog2(max2(WIDTH, GAP) + 1);

  // The timer counts the remaining cycles of the current phase, so a phase of
  // N cycles is loaded with N-1. GAP_RELOAD is only used when GAP > 0.
  localparam logic [TMR_W-1:0] WIDTH_RELOAD = TMR_W'(WIDTH - 1);
  localparam logic [TMR_W-1:0] GAP_RELOAD   = TMR_W'((GAP > 0) ? (GAP - 1) : 0);

  pstate_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             missed_q, missed_d;
  logic             missed_set;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;

  pulse_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    missed_set   = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = WIDTH_RELOAD;
    tmr_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pulse_sig) begin
          state_d  = STRETCH;
          tmr_load = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      STRETCH: begin
        if (pulse_sig && (RETRIG != 0)) begin
          // Reload beats expiry, so a pulse in the last cycle still extends.
          tmr_load = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          missed_set = pulse_sig;
          if (tmr_zero) begin
            if (GAP == 0) begin
              state_d = IDLE;
            end else begin
              state_d      = GUARD;
              tmr_load     = 1'b1;
              tmr_load_val = GAP_RELOAD;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end

      GUARD: begin
        missed_set = pulse_sig;
        if (tmr_zero) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A rejection in the same cycle as a clear must not be lost.
    if (missed_set) begin
      missed_d = 1'b1;
    end else if (clr_missed) begin
      missed_d = 1'b0;
    end else begin
      missed_d = missed_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  assign level_sig = (state_q == STRETCH);
  assign busy      = (state_q != IDLE);
  assign missed    = missed_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - scoreboard bench for pulse_stretch across four parameter sets
module tb_pulse_stretch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse_sig = 1'b0;
  logic clr_missed = 1'b0;

  always #5 clk = ~clk;

  // a: WIDTH=4 GAP=2 RETRIG=0, r: RETRIG=1, g: GAP=0, w: CNT_W=2
  logic       lvl_a, busy_a, mis_a;
  logic [7:0] cnt_a;
  logic       lvl_r, busy_r, mis_r;
  logic [7:0] cnt_r;
  logic       lvl_g, busy_g, mis_g;
  logic [7:0] cnt_g;
  logic       lvl_w, busy_w, mis_w;
  logic [1:0] cnt_w;

  pulse_stretch #(.WIDTH(4), .GAP(2), .RETRIG(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .pulse_sig(pulse_sig), .clr_missed(clr_missed),
    .level_sig(lvl_a), .busy(busy_a), .missed(mis_a), .pulse_cnt(cnt_a));
  pulse_stretch #(.WIDTH(4), .GAP(2), .RETRIG(1), .CNT_W(8)) dut_r (
    .clk(clk), .rst(rst), .pulse_sig(pulse_sig), .clr_missed(clr_missed),
    .level_sig(lvl_r), .busy(busy_r), .missed(mis_r), .pulse_cnt(cnt_r));
  pulse_stretch #(.WIDTH(4), .GAP(0), .RETRIG(0), .CNT_W(8)) dut_g (
    .clk(clk), .rst(rst), .pulse_sig(pulse_sig), .clr_missed(clr_missed),
    .level_sig(lvl_g), .busy(busy_g), .missed(mis_g), .pulse_cnt(cnt_g));
  pulse_stretch #(.WIDTH(4), .GAP(2), .RETRIG(0), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .pulse_sig(pulse_sig), .clr_missed(clr_missed),
    .level_sig(lvl_w), .busy(busy_w), .missed(mis_w), .pulse_cnt(cnt_w));

  typedef struct {
    int         cyc;
    logic       level;
    logic       busy;
    logic       missed;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_total  = 0;
  int   n_passed = 0;

  // Cycle c begins at a rising edge; inputs change 1 time unit later and
  // outputs are sampled on the following falling edge.
  task automatic drive(input logic r, input logic p, input logic cl);
    @(posedge clk);
    #1;
    rst        = r;
    pulse_sig  = p;
    clr_missed = cl;
  endtask

  task automatic test_reset_single();
    exp_t e, o;
    sb.delete();
    for (int c = 0; c <= 15; c++) begin
      drive(c <= 2, c == 5, 1'b0);
      if (c < 15) begin
        e.cyc = c + 1;
        e.level  = (e.cyc >= 6) && (e.cyc <= 9);
        e.busy   = (e.cyc >= 6) && (e.cyc <= 11);
        e.missed = 1'b0;
        e.cnt    = (e.cyc >= 6) ? 8'd1 : 8'd0;
        sb.push_back(e);
      end
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        o = sb.pop_front();
        n_total++;
        if ({lvl_a, busy_a, mis_a, cnt_a} !== {o.level, o.busy, o.missed, o.cnt})
          $display("FAIL reset_single cyc=%0d got lvl=%b busy=%b mis=%b cnt=%0d want lvl=%b busy=%b mis=%b cnt=%0d",
                   c, lvl_a, busy_a, mis_a, cnt_a, o.level, o.busy, o.missed, o.cnt);
        else n_passed++;
      end
    end
  endtask

  task automatic test_reject();
    exp_t e, o;
    sb.delete();
    for (int c = 0; c <= 18; c++) begin
      drive(c <= 2, (c == 5) || (c == 8) || (c == 10), c == 15);
      if (c < 18) begin
        e.cyc = c + 1;
        e.level  = (e.cyc >= 6) && (e.cyc <= 9);
        e.busy   = (e.cyc >= 6) && (e.cyc <= 11);
        e.missed = (e.cyc >= 9) && (e.cyc <= 15);
        e.cnt    = (e.cyc >= 6) ? 8'd1 : 8'd0;
        sb.push_back(e);
      end
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        o = sb.pop_front();
        n_total++;
        if ({lvl_a, busy_a, mis_a, cnt_a} !== {o.level, o.busy, o.missed, o.cnt})
          $display("FAIL reject cyc=%0d got lvl=%b busy=%b mis=%b cnt=%0d want lvl=%b busy=%b mis=%b cnt=%0d",
                   c, lvl_a, busy_a, mis_a, cnt_a, o.level, o.busy, o.missed, o.cnt);
        else n_passed++;
      end
    end
  endtask

  // Pulse in the last stretch cycle (9) together with clr_missed: must be
  // rejected and the set must win; a lone clear in cycle 13 then drops it.
  task automatic test_clr_collision();
    exp_t e, o;
    sb.delete();
    for (int c = 0; c <= 16; c++) begin
      drive(c <= 2, (c == 5) || (c == 9), (c == 9) || (c == 13));
      if (c < 16) begin
        e.cyc = c + 1;
        e.level  = (e.cyc >= 6) && (e.cyc <= 9);
        e.busy   = (e.cyc >= 6) && (e.cyc <= 11);
        e.missed = (e.cyc >= 10) && (e.cyc <= 13);
        e.cnt    = (e.cyc >= 6) ? 8'd1 : 8'd0;
        sb.push_back(e);
      end
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        o = sb.pop_front();
        n_total++;
        if ({lvl_a, busy_a, mis_a, cnt_a} !== {o.level, o.busy, o.missed, o.cnt})
          $display("FAIL clr_collision cyc=%0d got lvl=%b busy=%b mis=%b cnt=%0d want lvl=%b busy=%b mis=%b cnt=%0d",
                   c, lvl_a, busy_a, mis_a, cnt_a, o.level, o.busy, o.missed, o.cnt);
        else n_passed++;
      end
    end
  endtask

  // Second pulse lands in the first IDLE cycle after the guard.
  task automatic test_back_to_back();
    exp_t e, o;
    sb.delete();
    for (int c = 0; c <= 20; c++) begin
      drive(c <= 2, (c == 5) || (c == 12), 1'b0);
      if (c < 20) begin
        e.cyc = c + 1;
        e.level  = ((e.cyc >= 6) && (e.cyc <= 9)) || ((e.cyc >= 13) && (e.cyc <= 16));
        e.busy   = ((e.cyc >= 6) && (e.cyc <= 11)) || ((e.cyc >= 13) && (e.cyc <= 18));
        e.missed = 1'b0;
        e.cnt    = (e.cyc >= 13) ? 8'd2 : ((e.cyc >= 6) ? 8'd1 : 8'd0);
        sb.push_back(e);
      end
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        o = sb.pop_front();
        n_total++;
        if ({lvl_a, busy_a, mis_a, cnt_a} !== {o.level, o.busy, o.missed, o.cnt})
          $display("FAIL back_to_back cyc=%0d got lvl=%b busy=%b mis=%b cnt=%0d want lvl=%b busy=%b mis=%b cnt=%0d",
                   c, lvl_a, busy_a, mis_a, cnt_a, o.level, o.busy, o.missed, o.cnt);
        else n_passed++;
      end
    end
  endtask

  // Retrigger mid-window (8) and in the last stretch cycle (9).
  task automatic test_retrig();
    exp_t e, o;
    int   p2;
    for (int k = 0; k < 2; k++) begin
      p2 = 8 + k;
      sb.delete();
      for (int c = 0; c <= 18; c++) begin
        drive(c <= 2, (c == 5) || (c == p2), 1'b0);
        if (c < 18) begin
          e.cyc = c + 1;
          e.level  = (e.cyc >= 6) && (e.cyc <= p2 + 4);
          e.busy   = (e.cyc >= 6) && (e.cyc <= p2 + 6);
          e.missed = 1'b0;
          e.cnt    = (e.cyc > p2) ? 8'd2 : ((e.cyc >= 6) ? 8'd1 : 8'd0);
          sb.push_back(e);
        end
        @(negedge clk);
        if (sb.size() > 0 && sb[0].cyc == c) begin
          o = sb.pop_front();
          n_total++;
          if ({lvl_r, busy_r, mis_r, cnt_r} !== {o.level, o.busy, o.missed, o.cnt})
            $display("FAIL retrig p2=%0d cyc=%0d got lvl=%b busy=%b mis=%b cnt=%0d want lvl=%b busy=%b mis=%b cnt=%0d",
                     p2, c, lvl_r, busy_r, mis_r, cnt_r, o.level, o.busy, o.missed, o.cnt);
          else n_passed++;
        end
      end
    end
  endtask

  task automatic test_gap0();
    exp_t e, o;
    sb.delete();
    for (int c = 0; c <= 17; c++) begin
      drive(c <= 2, (c == 5) || (c == 10), 1'b0);
      if (c < 17) begin
        e.cyc = c + 1;
        e.level  = ((e.cyc >= 6) && (e.cyc <= 9)) || ((e.cyc >= 11) && (e.cyc <= 14));
        e.busy   = e.level;
        e.missed = 1'b0;
        e.cnt    = (e.cyc >= 11) ? 8'd2 : ((e.cyc >= 6) ? 8'd1 : 8'd0);
        sb.push_back(e);
      end
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        o = sb.pop_front();
        n_total++;
        if ({lvl_g, busy_g, mis_g, cnt_g} !== {o.level, o.busy, o.missed, o.cnt})
          $display("FAIL gap0 cyc=%0d got lvl=%b busy=%b mis=%b cnt=%0d want lvl=%b busy=%b mis=%b cnt=%0d",
                   c, lvl_g, busy_g, mis_g, cnt_g, o.level, o.busy, o.missed, o.cnt);
        else n_passed++;
      end
    end
  endtask

  // Reset in cycle 7 mid-stretch, with missed set and a pulse in the reset cycle.
  task automatic test_mid_reset();
    exp_t e, o;
    sb.delete();
    for (int c = 0; c <= 13; c++) begin
      drive((c <= 2) || (c == 7), (c == 5) || (c == 6) || (c == 7), 1'b0);
      if (c < 13) begin
        e.cyc = c + 1;
        e.level  = (e.cyc >= 6) && (e.cyc <= 7);
        e.busy   = e.level;
        e.missed = (e.cyc == 7);
        e.cnt    = e.level ? 8'd1 : 8'd0;
        sb.push_back(e);
      end
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        o = sb.pop_front();
        n_total++;
        if ({lvl_a, busy_a, mis_a, cnt_a} !== {o.level, o.busy, o.missed, o.cnt})
          $display("FAIL mid_reset cyc=%0d got lvl=%b busy=%b mis=%b cnt=%0d want lvl=%b busy=%b mis=%b cnt=%0d",
                   c, lvl_a, busy_a, mis_a, cnt_a, o.level, o.busy, o.missed, o.cnt);
        else n_passed++;
      end
    end
  endtask

  // Five pulses spaced 8 cycles apart on the 2-bit counter: 1, 2, 3, 0, 1.
  task automatic test_wrap();
    exp_t e, o;
    int   np;
    logic in_win;
    sb.delete();
    for (int c = 0; c <= 46; c++) begin
      drive(c <= 2, (c >= 5) && (c <= 37) && (((c - 5) % 8) == 0), 1'b0);
      if (c < 46) begin
        e.cyc  = c + 1;
        np     = 0;
        in_win = 1'b0;
        for (int i = 0; i < 5; i++) begin
          if (5 + 8 * i < e.cyc) np++;
          if ((e.cyc >= 6 + 8 * i) && (e.cyc <= 9 + 8 * i)) in_win = 1'b1;
        end
        e.level  = in_win;
        e.busy   = 1'bx;
        e.missed = 1'b0;
        e.cnt    = 8'(np % 4);
        sb.push_back(e);
      end
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        o = sb.pop_front();
        n_total++;
        if ({lvl_w, mis_w, 6'd0, cnt_w} !== {o.level, o.missed, o.cnt})
          $display("FAIL wrap cyc=%0d got lvl=%b mis=%b cnt=%0d want lvl=%b mis=%b cnt=%0d",
                   c, lvl_w, mis_w, cnt_w, o.level, o.missed, o.cnt);
        else n_passed++;
      end
    end
  endtask

  initial begin
    test_reset_single();
    test_reject();
    test_clr_collision();
    test_back_to_back();
    test_retrig();
    test_gap0();
    test_mid_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
